pixel_readout_receiver: RTL and testbench
=========================================

# pixel_readout_receiver

Receiving end of the pixel-array readout bus. Samples 32-bit words that the pixel top drives on `databus` (four 8-bit pixel values per word), buffers them in a small word FIFO, and re-emits them as a byte-wide pixel stream with valid/ready handshake and end-of-frame marking. Sits between the pixel top readout and the downstream frame/host logic; also tracks frame count and sticky error conditions.

## Interface
- `ROWS`, 2, number of 32-bit words per frame (≥1)
- `FIFO_DEPTH`, 8, word FIFO depth (power of two, ≥2)
- `CNT_W`, 16, width of frame counter
- `clk` in 1, system clock, all logic rising-edge
- `reset` in 1, asynchronous, active-low reset (0 = reset asserted)
- `databus` in 32, readout word; pixel0 = [7:0], pixel1 = [15:8], pixel2 = [23:16], pixel3 = [31:24]
- `bus_valid` in 1, one-cycle strobe: `databus` valid this cycle
- `frame_start` in 1, one-cycle strobe marking start of a new frame readout
- `pix_data` out 8, pixel value
- `pix_valid` out 1, `pix_data` valid
- `pix_ready` in 1, downstream accepts pixel
- `pix_last` out 1, qualifies `pix_data` as final pixel of frame
- `frame_count` out CNT_W, number of complete frames written into FIFO, wraps
- `overflow` out 1, sticky: word dropped due to full FIFO
- `frame_err` out 1, sticky: short frame or excess words
- `clear_err` in 1, synchronous clear of `overflow` and `frame_err`

## Operation
- Word index counter `widx` (0..ROWS); `frame_start` sets `widx`=0; accepted word increments it.
- `frame_start` and `bus_valid` in same cycle: frame_start applied first, word taken as index 0.
- `frame_start` while 0 < `widx` < ROWS: `frame_err` set; partial words already in FIFO stay, no last tag issued.
- `bus_valid` with `widx`==ROWS (frame already complete): word dropped, `frame_err` set, FIFO untouched.
- `bus_valid` before any `frame_start` since reset: `widx` resets to ROWS, so word dropped, `frame_err` set.
- Accepted word pushed with tag `last` = (`widx`==ROWS-1); on that push `frame_count` += 1 (mod 2^CNT_W).
- FIFO full and no pop this cycle: word dropped, `overflow` set, `widx` still advances (frame counting stays aligned); a dropped last word does not increment `frame_count`.
- FIFO full with pop same cycle: push accepted.
- Unpacker: holds one word + byte pointer `bp` (0..3). States EMPTY / SEND.
  - EMPTY: if FIFO non-empty, pop and load, `bp`=0, go SEND.
  - SEND: `pix_valid`=1, `pix_data`=byte `bp`; on `pix_ready`: `bp`+1; at `bp`=3 and ready, pop next word if available (stay SEND, `bp`=0) else EMPTY.
- `pix_last` = SEND & `bp`==3 & word tag `last`.
- `pix_data`/`pix_last` held stable while `pix_valid` & !`pix_ready`.
- `clear_err` has priority over a new error event in the same cycle? No: set wins over clear in same cycle.

## Timing
- Reset (reset=0): FIFO empty, unpacker EMPTY, `widx`=ROWS, `pix_data`=0, `pix_valid`=0, `pix_last`=0, `frame_count`=0, `overflow`=0, `frame_err`=0. Reset mid-frame flushes all buffered data.
- Latency: word sampled at edge N (FIFO write); unpacker loads at edge N+1; `pix_valid` high after N+1 with byte 0 (when FIFO and unpacker previously empty).
- Throughput: 1 pixel/cycle with `pix_ready` held high; back-to-back words stream with no bubble. Sustained input ≤ 1 word per 4 cycles avoids overflow.
- `frame_count` updates after the edge sampling the last word, independent of downstream drain.
- All outputs registered.

## Test plan
- Reset, `frame_start`, 2 words 0x04030201, 0x08070605 with `pix_ready`=1 -> pix stream 01..08, `pix_valid` first high 2 edges after word 0, `pix_last` only on 08, `frame_count`=1.
- Backpressure: same frame, `pix_ready` toggled 1/0 each cycle -> identical byte order, data stable during stalls, no loss.
- `pix_ready`=0, push 10 words (5 frames) with FIFO_DEPTH=8 -> 8 words buffered + 1 in unpacker? no: unpacker loads 1, FIFO holds 8, 10th word dropped, `overflow`=1, `frame_count`=4; `clear_err` -> `overflow`=0.
- `frame_start`, 1 word, `frame_start`, 2 words -> `frame_err`=1, 12 pixels out, single `pix_last` on final byte, `frame_count`=1.
- Third word after complete frame, and word before first `frame_start` -> dropped, `frame_err`=1, no output for them.
- Assert reset mid-stream with 3 words buffered -> all outputs to reset values immediately; after release, new frame streams normally.

Source files
------------

// File: rtl/pixel_readout_receiver.sv
// -----------------------------------------------------------------------------
// pixel_readout_receiver
//
// Receiving end of the pixel-array readout bus. 32-bit readout words (four
// 8-bit pixels each, pixel0 in the low byte) are framed by a word-index
// counter, buffered in a word FIFO, and re-emitted as a byte-wide pixel
// stream with a valid/ready handshake. The final pixel of each frame is
// marked with pix_last. The block also counts completed frames and keeps
// sticky overflow and framing-error flags.
//
// Parameters
//   ROWS        32-bit words per frame (>= 1)
//   FIFO_DEPTH  word FIFO depth (power of two, >= 2)
//   CNT_W       frame counter width
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   databus      in   readout word, pixel0 = [7:0] .. pixel3 = [31:24]
//   bus_valid    in   databus valid this cycle (one-cycle strobe)
//   frame_start  in   start of a new frame readout (one-cycle strobe)
//   pix_data     out  pixel value
//   pix_valid    out  pix_data valid
//   pix_ready    in   downstream accepts the pixel
//   pix_last     out  pix_data is the final pixel of a frame
//   frame_count  out  complete frames written into the FIFO (wraps)
//   overflow     out  sticky: a word was dropped because the FIFO was full
//   frame_err    out  sticky: short frame, excess word or word before start
//   clear_err    in   synchronous clear of overflow and frame_err
// -----------------------------------------------------------------------------
module pixel_readout_receiver #(
   parameter int ROWS       = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      databus,
   input  logic             bus_valid,
   input  logic             frame_start,
   output logic [7:0]       pix_data,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic             pix_last,
   output logic [CNT_W-1:0] frame_count,
   output logic             overflow,
   output logic             frame_err,
   input  logic             clear_err
);

   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int WIDX_W = $clog2(ROWS + 1);

   localparam logic [WIDX_W-1:0] ROWS_W   = WIDX_W'(ROWS);
   localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(ROWS - 1);

   typedef enum logic {
      ST_EMPTY,
      ST_SEND
   } state_e;

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   // Framing
   logic [WIDX_W-1:0] widx_q, widx_d;
   logic [WIDX_W-1:0] eff_widx;
   logic              word_ok;
   logic              is_last;
   logic              start_err;
   logic              excess_err;
   logic              drop_full;
   logic [CNT_W-1:0]  frame_count_q, frame_count_d;
   logic              overflow_q, overflow_d;
   logic              frame_err_q, frame_err_d;

   // FIFO
   logic [32:0]       mem_q [FIFO_DEPTH];
   logic [AW:0]       wptr_q, rptr_q;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [32:0]       fifo_rdata;

   // Unpacker
   state_e            state_q;
   logic [31:0]       word_q;
   logic              last_q;
   logic [1:0]        bp_q;
   logic [7:0]        pix_data_q;
   logic              pix_valid_q;
   logic              pix_last_q;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

   // ---------------------------------------------------------------------------
   // Framing and error detection
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a value on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      // A frame_start in the same cycle as a word restarts the frame first,
      // so the word is taken as index 0.
      eff_widx   = frame_start ? '0 : widx_q;

      // Restarting while a frame is partially received is a short frame.
      // Partial words already buffered stay and carry no last tag.
      start_err  = frame_start && (widx_q != '0) && (widx_q != ROWS_W);

      // widx == ROWS means "no frame open": after a complete frame, or since
      // reset until the first frame_start.
      word_ok    = bus_valid && (eff_widx != ROWS_W);
      excess_err = bus_valid && !word_ok;
      is_last    = (eff_widx == LAST_IDX);

      // A pop in the same cycle frees a slot, so a full FIFO can still accept.
      push       = word_ok && (!fifo_full || pop);
      drop_full  = word_ok && fifo_full && !pop;

      // The index advances even on a dropped word so later frames stay aligned.
      widx_d     = word_ok ? eff_widx + 1'b1 : eff_widx;

      // A dropped final word does not complete a frame.
      frame_count_d = (push && is_last) ? frame_count_q + 1'b1 : frame_count_q;

      // A new error event in the same cycle as clear_err wins.
      overflow_d  = drop_full || (overflow_q && !clear_err);
      frame_err_d = start_err || excess_err || (frame_err_q && !clear_err);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         widx_q        <= ROWS_W;
         frame_count_q <= '0;
         overflow_q    <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         widx_q        <= widx_d;
         frame_count_q <= frame_count_d;
         overflow_q    <= overflow_d;
         frame_err_q   <= frame_err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Word FIFO: extra pointer bit distinguishes full from empty.
   // ---------------------------------------------------------------------------
   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                       (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign fifo_rdata = mem_q[rptr_q[AW-1:0]];

   // NOTE: the storage array has no reset; emptiness is defined by the
   // pointers alone, which keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]] <= {is_last, databus};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Unpacker: one word held, bytes sent in order 0..3.
   // ---------------------------------------------------------------------------
   // Load when idle, or when the last byte of the current word is accepted so
   // back-to-back words stream without a bubble.
   assign pop = !fifo_empty &&
                ((state_q == ST_EMPTY) ||
                 (pix_ready && (bp_q == 2'd3)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_EMPTY;
         word_q      <= '0;
         last_q      <= 1'b0;
         bp_q        <= '0;
         pix_data_q  <= '0;
         pix_valid_q <= 1'b0;
         pix_last_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (pop) begin
                  state_q     <= ST_SEND;
                  word_q      <= fifo_rdata[31:0];
                  last_q      <= fifo_rdata[32];
                  bp_q        <= 2'd0;
                  pix_data_q  <= fifo_rdata[7:0];
                  pix_valid_q <= 1'b1;
                  pix_last_q  <= 1'b0;
               end
            end
            ST_SEND: begin
               // Without pix_ready nothing changes, which holds pix_data and
               // pix_last stable during a stall.
               if (pix_ready) begin
                  if (bp_q == 2'd3) begin
                     if (pop) begin
                        word_q      <= fifo_rdata[31:0];
                        last_q      <= fifo_rdata[32];
                        bp_q        <= 2'd0;
                        pix_data_q  <= fifo_rdata[7:0];
                        pix_valid_q <= 1'b1;
                        pix_last_q  <= 1'b0;
                     end else begin
                        state_q     <= ST_EMPTY;
                        bp_q        <= 2'd0;
                        pix_valid_q <= 1'b0;
                        pix_last_q  <= 1'b0;
                     end
                  end else begin
                     bp_q        <= bp_q + 2'd1;
                     pix_data_q  <= byte_sel(word_q, bp_q + 2'd1);
                     // Next byte is byte 3 of a frame's final word.
                     pix_last_q  <= last_q && (bp_q == 2'd2);
                  end
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               pix_valid_q <= 1'b0;
               pix_last_q  <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign pix_data    = pix_data_q;
   assign pix_valid   = pix_valid_q;
   assign pix_last    = pix_last_q;
   assign frame_count = frame_count_q;
   assign overflow    = overflow_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_pixel_readout_receiver.sv
// -----------------------------------------------------------------------------
// tb_pixel_readout_receiver
//
// Scenario tasks drive readout words; every accepted word pushes its four
// expected pixels (with the expected last flag) onto a queue, and a monitor
// pops and compares on each pixel handshake. Inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge or 1 ns after a rise.
// -----------------------------------------------------------------------------
module tb_pixel_readout_receiver;

   localparam int ROWS       = 2;
   localparam int FIFO_DEPTH = 8;
   localparam int CNT_W      = 16;

   logic             clk;
   logic             reset;
   logic [31:0]      databus;
   logic             bus_valid;
   logic             frame_start;
   logic [7:0]       pix_data;
   logic             pix_valid;
   logic             pix_ready;
   logic             pix_last;
   logic [CNT_W-1:0] frame_count;
   logic             overflow;
   logic             frame_err;
   logic             clear_err;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } pix_t;

   pix_t exp_q[$];
   pix_t exp_e;
   int   total = 0;
   int   bad   = 0;

   logic       prev_stall;
   logic [7:0] prev_d;
   logic       prev_l;

   pixel_readout_receiver #(
      .ROWS       (ROWS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .databus     (databus),
      .bus_valid   (bus_valid),
      .frame_start (frame_start),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_last    (pix_last),
      .frame_count (frame_count),
      .overflow    (overflow),
      .frame_err   (frame_err),
      .clear_err   (clear_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: scoreboard compare on handshakes, hold check during stalls.
   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            total++;
            if (pix_valid !== 1'b1 || pix_data !== prev_d || pix_last !== prev_l) begin
               bad++;
               $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                        pix_valid, pix_data, pix_last, prev_d, prev_l);
            end
         end
         if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pixel: got d=%h l=%b, want no pixel", pix_data, pix_last);
            end else begin
               exp_e = exp_q.pop_front();
               if (pix_data !== exp_e.d || pix_last !== exp_e.l) begin
                  bad++;
                  $display("FAIL pixel: got d=%h l=%b, want d=%h l=%b",
                           pix_data, pix_last, exp_e.d, exp_e.l);
               end
            end
         end
         prev_stall = (pix_valid === 1'b1) && (pix_ready !== 1'b1);
         prev_d     = pix_data;
         prev_l     = pix_last;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] w, input logic last);
      pix_t e;
      for (int i = 0; i < 4; i++) begin
         e.d = w[8*i +: 8];
         e.l = last && (i == 3);
         exp_q.push_back(e);
      end
   endtask

   // One bus cycle; acc/last state what the bench expects of this word.
   task automatic send(input logic fs, input logic [31:0] w, input logic acc, input logic last);
      frame_start = fs;
      bus_valid   = 1'b1;
      databus     = w;
      tick();
      frame_start = 1'b0;
      bus_valid   = 1'b0;
      if (acc) push_exp(w, last);
   endtask

   task automatic do_reset;
      reset       = 1'b0;
      bus_valid   = 1'b0;
      frame_start = 1'b0;
      clear_err   = 1'b0;
      pix_ready   = 1'b0;
      databus     = '0;
      repeat (2) tick();
      exp_q.delete();
      reset = 1'b1;
      tick();
   endtask

   // Run until every expected pixel is out and the stream is idle.
   task automatic drain(input logic toggle);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (exp_q.size() == 0 && pix_valid === 1'b0) begin
            done = 1'b1;
         end else begin
            pix_ready = toggle ? ~pix_ready : 1'b1;
            tick();
         end
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL drain_timeout: got %0d pixels outstanding, want 0", exp_q.size());
      end
      // Give any stray pixel a chance to show up.
      pix_ready = 1'b1;
      repeat (6) tick();
   endtask

   function automatic logic [31:0] wd(input int k);
      return 32'h11223344 ^ (32'(k) * 32'h01010101);
   endfunction

   task automatic test_reset;
      reset       = 1'b0;
      bus_valid   = 1'b0;
      frame_start = 1'b0;
      clear_err   = 1'b0;
      pix_ready   = 1'b0;
      databus     = '0;
      tick();
      total++;
      if ({pix_valid, pix_last, pix_data, frame_count, overflow, frame_err} !== '0) begin
         bad++;
         $display("FAIL reset_values: got v=%b l=%b d=%h cnt=%0d ovf=%b ferr=%b, want all 0",
                  pix_valid, pix_last, pix_data, frame_count, overflow, frame_err);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      do_reset();
      pix_ready = 1'b1;
      send(1'b1, 32'h04030201, 1'b1, 1'b0);
      total++;
      if (pix_valid !== 1'b0) begin
         bad++;
         $display("FAIL latency_early: got pix_valid=%b one edge after word, want 0", pix_valid);
      end
      send(1'b0, 32'h08070605, 1'b1, 1'b1);
      total++;
      if (pix_valid !== 1'b1 || pix_data !== 8'h01) begin
         bad++;
         $display("FAIL latency_first: got v=%b d=%h, want v=1 d=01", pix_valid, pix_data);
      end
      total++;
      if (frame_count !== 16'd1) begin
         bad++;
         $display("FAIL count_early: got %0d, want 1", frame_count);
      end
      drain(1'b0);
      total++;
      if (frame_count !== 16'd1 || overflow !== 1'b0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL basic_status: got cnt=%0d ovf=%b ferr=%b, want 1 0 0",
                  frame_count, overflow, frame_err);
      end
   endtask

   task automatic test_backpressure;
      do_reset();
      send(1'b1, 32'h04030201, 1'b1, 1'b0);
      send(1'b0, 32'h08070605, 1'b1, 1'b1);
      drain(1'b1);
      total++;
      if (frame_count !== 16'd1) begin
         bad++;
         $display("FAIL bp_count: got %0d, want 1", frame_count);
      end
   endtask

   task automatic test_overflow;
      do_reset();
      for (int f = 0; f < 5; f++) begin
         send(1'b1, wd(2*f), 1'b1, 1'b0);
         if (f == 4) begin
            total++;
            if (overflow !== 1'b0) begin
               bad++;
               $display("FAIL ovf_early: got %b before 10th word, want 0", overflow);
            end
         end
         send(1'b0, wd(2*f+1), f != 4, 1'b1);
      end
      total++;
      if (overflow !== 1'b1 || frame_count !== 16'd4 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL ovf_status: got ovf=%b cnt=%0d ferr=%b, want 1 4 0",
                  overflow, frame_count, frame_err);
      end
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear: got %b, want 0", overflow);
      end
      drain(1'b0);
   endtask

   task automatic test_short_frame;
      do_reset();
      pix_ready = 1'b1;
      send(1'b1, wd(20), 1'b1, 1'b0);
      send(1'b1, wd(21), 1'b1, 1'b0);
      send(1'b0, wd(22), 1'b1, 1'b1);
      total++;
      if (frame_err !== 1'b1) begin
         bad++;
         $display("FAIL short_err: got %b, want 1", frame_err);
      end
      drain(1'b0);
      total++;
      if (frame_count !== 16'd1) begin
         bad++;
         $display("FAIL short_count: got %0d, want 1", frame_count);
      end
   endtask

   task automatic test_drops;
      do_reset();
      pix_ready = 1'b1;
      send(1'b0, wd(30), 1'b0, 1'b0);
      total++;
      if (frame_err !== 1'b1) begin
         bad++;
         $display("FAIL prestart_err: got %b, want 1", frame_err);
      end
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      total++;
      if (frame_err !== 1'b0) begin
         bad++;
         $display("FAIL ferr_clear: got %b, want 0", frame_err);
      end
      send(1'b1, wd(31), 1'b1, 1'b0);
      send(1'b0, wd(32), 1'b1, 1'b1);
      total++;
      if (frame_err !== 1'b0) begin
         bad++;
         $display("FAIL exact_frame_err: got %b, want 0", frame_err);
      end
      // Excess word with clear_err in the same cycle: the set wins.
      clear_err = 1'b1;
      send(1'b0, wd(33), 1'b0, 1'b0);
      clear_err = 1'b0;
      total++;
      if (frame_err !== 1'b1) begin
         bad++;
         $display("FAIL excess_err: got %b, want 1", frame_err);
      end
      drain(1'b0);
      total++;
      if (frame_count !== 16'd1) begin
         bad++;
         $display("FAIL drops_count: got %0d, want 1", frame_count);
      end
   endtask

   task automatic test_reset_midstream;
      do_reset();
      send(1'b1, wd(40), 1'b1, 1'b0);
      send(1'b0, wd(41), 1'b1, 1'b1);
      send(1'b1, wd(42), 1'b1, 1'b0);
      tick();
      #2;
      reset = 1'b0;
      #1;
      total++;
      if ({pix_valid, pix_last, pix_data, frame_count, overflow, frame_err} !== '0) begin
         bad++;
         $display("FAIL midreset_values: got v=%b l=%b d=%h cnt=%0d ovf=%b ferr=%b, want all 0",
                  pix_valid, pix_last, pix_data, frame_count, overflow, frame_err);
      end
      exp_q.delete();
      tick();
      reset     = 1'b1;
      tick();
      pix_ready = 1'b1;
      send(1'b1, wd(43), 1'b1, 1'b0);
      send(1'b0, wd(44), 1'b1, 1'b1);
      drain(1'b0);
      total++;
      if (frame_count !== 16'd1 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL post_reset: got cnt=%0d ferr=%b, want 1 0", frame_count, frame_err);
      end
   endtask

   initial begin
      prev_stall = 1'b0;
      prev_d     = '0;
      prev_l     = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_short_frame();
      test_drops();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
